// File: rtl/sram_resp_pkg.sv
// sram_resp_pkg
//   Shared types and constants for sram_responder and its storage array.
//   - resp_state_t : responder FSM state (INIT clears the array, READY serves)
//   - ERR_CNT_W / ERR_CNT_MAX : width and saturation value of the error counter
//   - BE_W : byte-enable width of one storage word
package sram_resp_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } resp_state_t;

  localparam int                   ERR_CNT_W   = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;
  localparam int                   BE_W        = 4;

  // Adds 0..2 to the error count and clamps at ERR_CNT_MAX.
  function automatic logic [ERR_CNT_W-1:0] err_sat_add(
    input logic [ERR_CNT_W-1:0] cnt,
    input logic [1:0]           inc
  );
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_CNT_W-1){1'b0}}, inc};
    return sum[ERR_CNT_W] ? ERR_CNT_MAX : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sram_bram_dp.sv
// sram_bram_dp
//   True dual-port word array with byte enables, registered read data and
//   read-first behaviour on both ports. The array itself has no reset.
//   Ports:
//     clk                 clock
//     i_a_en / i_b_en     port enable (read, and write where we != 0)
//     i_a_we / i_b_we     byte write enables
//     i_a_addr / i_b_addr word index
//     i_a_wdata / i_b_wdata write data
//     o_a_rdata / o_b_rdata pre-write word at the addressed index
//   On a same-byte collision port A wins.
module sram_bram_dp
  import sram_resp_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              i_a_en,
  input  logic [BE_W-1:0]   i_a_we,
  input  logic [AW-1:0]     i_a_addr,
  input  logic [8*BE_W-1:0] i_a_wdata,
  output logic [8*BE_W-1:0] o_a_rdata,
  input  logic              i_b_en,
  input  logic [BE_W-1:0]   i_b_we,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [8*BE_W-1:0] i_b_wdata,
  output logic [8*BE_W-1:0] o_b_rdata
);

  logic [8*BE_W-1:0] r_mem [2**AW];
  logic [8*BE_W-1:0] r_a_q;
  logic [8*BE_W-1:0] r_b_q;

  // Port B writes are issued first so port A's nonblocking update lands last.
  always_ff @(posedge clk) begin
    if (i_b_en) begin
      r_b_q <= r_mem[i_b_addr];
      for (int i = 0; i < BE_W; i++) begin
        if (i_b_we[i]) r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
      end
    end
    if (i_a_en) begin
      r_a_q <= r_mem[i_a_addr];
      for (int i = 0; i < BE_W; i++) begin
        if (i_a_we[i]) r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
      end
    end
  end

  assign o_a_rdata = r_a_q;
  assign o_b_rdata = r_b_q;

endmodule

// File: rtl/sram_responder.sv
// sram_responder
//   Memory-side responder for the core's inst_sram_* / data_sram_* masters.
//   Clears its array after reset, then serves instruction reads (port B) and
//   data reads/writes with byte enables (port A) with one-cycle latency.
//   Ports:
//     clk, rst (async, active low)
//     inst_sram_en/wen/addr/wdata -> inst_sram_rdata   (wen/wdata unused)
//     data_sram_en/wen/addr/wdata -> data_sram_rdata   (wen=0 means read)
//     init_done  high once the clear sequence is complete
//     err_cnt    saturating count of out-of-window requests
//
//   state | meaning
//   INIT  | writing zero to word[clr_idx] each cycle; requests ignored
//   READY | serving both ports; terminal until reset
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_sram_en,
  input  logic [BE_W-1:0]      inst_sram_wen,
  input  logic [31:0]          inst_sram_addr,
  input  logic [31:0]          inst_sram_wdata,
  output logic [31:0]          inst_sram_rdata,
  input  logic                 data_sram_en,
  input  logic [BE_W-1:0]      data_sram_wen,
  input  logic [31:0]          data_sram_addr,
  input  logic [31:0]          data_sram_wdata,
  output logic [31:0]          data_sram_rdata,
  output logic                 init_done,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int AW     = DEPTH_LOG2;
  localparam int HI_LSB = 2 + DEPTH_LOG2;

  resp_state_t           r_state;
  resp_state_t           w_state_nxt;
  logic [AW-1:0]         r_clr_idx;
  logic                  w_clr_last;
  logic                  w_ready;
  logic                  w_inst_in;
  logic                  w_data_in;
  logic                  w_inst_acc;
  logic                  w_data_acc;
  logic                  w_inst_oow;
  logic                  w_data_oow;
  logic [1:0]            w_err_inc;
  logic                  r_inst_zero;
  logic                  r_data_zero;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  w_a_en;
  logic [BE_W-1:0]       w_a_we;
  logic [AW-1:0]         w_a_addr;
  logic [31:0]           w_a_wdata;
  logic [31:0]           w_a_rdata;
  logic [31:0]           w_b_rdata;
  logic                  w_unused;

  assign w_unused = ^{inst_sram_wen, inst_sram_wdata,
                      inst_sram_addr[1:0], data_sram_addr[1:0]};

  assign w_clr_last = (r_clr_idx == {AW{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_clr_last) w_state_nxt = READY;
      READY:   w_state_nxt = READY;
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= INIT;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  assign w_ready    = (r_state == READY);
  assign w_inst_in  = (inst_sram_addr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign w_data_in  = (data_sram_addr[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign w_inst_acc = w_ready & inst_sram_en &  w_inst_in;
  assign w_data_acc = w_ready & data_sram_en &  w_data_in;
  assign w_inst_oow = w_ready & inst_sram_en & ~w_inst_in;
  assign w_data_oow = w_ready & data_sram_en & ~w_data_in;
  assign w_err_inc  = {1'b0, w_inst_oow} + {1'b0, w_data_oow};

  // Port A carries the clear writes while INIT, the data port afterwards.
  assign w_a_en    = ~w_ready | w_data_acc;
  assign w_a_we    = w_ready ? data_sram_wen : {BE_W{1'b1}};
  assign w_a_addr  = w_ready ? data_sram_addr[HI_LSB-1:2] : r_clr_idx;
  assign w_a_wdata = w_ready ? data_sram_wdata : 32'h0;

  sram_bram_dp #(
    .AW(AW)
  ) u_bram (
    .clk       (clk),
    .i_a_en    (w_a_en),
    .i_a_we    (w_a_we),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (w_a_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_en    (w_inst_acc),
    .i_b_we    ({BE_W{1'b0}}),
    .i_b_addr  (inst_sram_addr[HI_LSB-1:2]),
    .i_b_wdata (32'h0),
    .o_b_rdata (w_b_rdata)
  );

  // The array read registers have no reset, so a reset-cleared zero flag
  // masks them; an idle port leaves both the flag and the array output alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst_zero <= 1'b1;
      r_data_zero <= 1'b1;
      r_err_cnt   <= '0;
    end else if (!w_ready) begin
      r_inst_zero <= 1'b1;
      r_data_zero <= 1'b1;
    end else begin
      if (inst_sram_en) r_inst_zero <= ~w_inst_in;
      if (data_sram_en) r_data_zero <= ~w_data_in;
      r_err_cnt <= err_sat_add(r_err_cnt, w_err_inc);
    end
  end

  assign inst_sram_rdata = r_inst_zero ? 32'h0 : w_b_rdata;
  assign data_sram_rdata = r_data_zero ? 32'h0 : w_a_rdata;
  assign init_done       = w_ready;
  assign err_cnt         = r_err_cnt;

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the core's `inst_sram_*` and `data_sram_*` master interfaces, used in simulation and FPGA SoC builds. It owns a word-addressed storage array. Instruction fetches are served on a read-only port and data accesses on a read/write port with byte enables. Read data is returned with the fixed one-cycle latency that the core's ID and MEM stages expect. After reset it clears the array with an internal state machine, signals completion, and counts out-of-window accesses.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: array holds 2^DEPTH_LOG2 32-bit words (16 KiB).
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be aligned to 4·2^DEPTH_LOG2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inst_sram_en`  in  1  instruction read request.
- `inst_sram_wen`  in  4  ignored; the instruction port never writes.
- `inst_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `inst_sram_wdata`  in  32  ignored.
- `inst_sram_rdata`  out  32  instruction read data.
- `data_sram_en`  in  1  data request.
- `data_sram_wen`  in  4  byte write enables; bit i writes byte i. 4'b0000 means read.
- `data_sram_addr`  in  32  byte address; bits [1:0] ignored.
- `data_sram_wdata`  in  32  write data.
- `data_sram_rdata`  out  32  data read data.
- `init_done`  out  1  high once the clear sequence has finished. The SoC holds the core in reset until this is high.
- `err_cnt`  out  16  saturating count of out-of-window requests.

## Operation
- Reset values: `inst_sram_rdata`=0, `data_sram_rdata`=0, `init_done`=0, `err_cnt`=0, FSM=INIT, clear index=0.
- State INIT:
  - Writes 0 to word[idx] on each edge, then increments idx.
  - After the edge that clears word 2^DEPTH_LOG2−1, moves to READY.
  - All requests are ignored and both rdata outputs stay 0.
- State READY:
  - `init_done`=1.
  - Terminal until `rst` is asserted.
- Window check: a request is in window iff `addr[31:2+DEPTH_LOG2] == BASE_ADDR[31:2+DEPTH_LOG2]`. Word index = `addr[DEPTH_LOG2+1:2]`.
- Data read (`en`=1, `wen`=0, in window): the next-cycle `data_sram_rdata` is word[index].
- Data write (`en`=1, `wen`≠0, in window):
  - Only the enabled bytes are updated.
  - The next-cycle `data_sram_rdata` is the pre-write word (read-first).
- Instruction read: the next-cycle `inst_sram_rdata` is word[index].
- Out-of-window request on either port:
  - No array change.
  - The corresponding rdata becomes 0.
  - `err_cnt` += 1, saturating at 16'hFFFF.
  - If both ports are out of window in the same cycle, `err_cnt` += 2, saturating.
- `en`=0: rdata holds its previous value.
- Same-word data write and instruction read in one cycle: the instruction port returns the old word. Later reads see the new word.

## Timing
- Request sampled at edge N; rdata valid from edge N to edge N+1. Latency is 1 cycle with no wait states and no backpressure.
- A write at edge N is visible to a read sampled at edge N+1 on either port.
- Clear sequence: with reset released before edge 1, `init_done` rises after edge 2^DEPTH_LOG2.
- Asserting `rst` at any time, including mid-INIT, asynchronously forces all outputs to their reset values. The clear restarts from index 0 after release.

## Structure
- Package `sram_resp_pkg` holds:
  - the FSM state typedef (INIT, READY);
  - the error-counter width and saturation constant;
  - the byte-enable width constant (4).
- Sub-module `sram_bram_dp` is a true dual-port array with byte enables and read-first behaviour on both ports.
  - Port A: data port, multiplexed with the clear writes during INIT.
  - Port B: instruction port.
  - No reset on the array.
- The top level contains the FSM, clear counter, window decode, rdata zero-muxing, error counter, and output registers.

## Test plan
Test parameters: `DEPTH_LOG2`=4, `BASE_ADDR`=0.

1. Release reset, then count edges → `init_done` rises exactly after edge 16. Data reads of 0x00 and 0x3C then return 0.
2. Data write 0xDEADBEEF, `wen`=4'hF, addr 0x10, then read addr 0x10 on both ports → both rdata 0xDEADBEEF one cycle later. The write cycle's `data_sram_rdata` is 0.
3. Word 0x14 holds 0x11223344. Write `wen`=4'b0010, wdata 0x0000_5500 → the next read of 0x14 returns 0x11225544.
4. Word 0x8 holds 0x1. Data write 0xAAAAAAAA to 0x8 and instruction read of 0x8 in the same cycle → `inst_sram_rdata`=0x1. The next instruction read returns 0xAAAAAAAA.
5. Write to 0x40 (out of window) → array unchanged, rdata 0, `err_cnt`=1. Then both ports out of window for 40000 cycles → `err_cnt`=0xFFFF and held there.
6. Assert `rst` when the clear index is 7, after word 3 has been written with a nonzero value → outputs go to 0 immediately. After release the clear restarts, `init_done` rises after 16 edges, and word 3 reads 0.
